cpu_regfile_mp: RTL and testbench
=================================

// Module: cpu_regfile_mp
// PURPOSE
//  Parametrised general-purpose register file for the CPU datapath.
//  - Two combinational read ports and one write port, with optional write-to-read bypass.
//  - Per-register pending scoreboard for in-flight producers.
//  - Hardware bulk-clear sequencer that zeroes one register per cycle.
//  Sits between the decoder (read/issue) and writeback (write) stages; does not drive the shared data bus.
// PARAMETERS
//  DATA_W   8  register width in bits
//  ADDR_W   3  address width; DEPTH = 2**ADDR_W registers
//  BYPASS   1  1: a same-cycle write is visible on the read ports; 0: array contents only
//  ZERO_R0  0  1: register 0 is hardwired to zero, ignores writes, never pending
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        synchronous, active-high reset
//  rd_addr_a   in   ADDR_W   read port A address
//  rd_data_a   out  DATA_W   read port A data (combinational)
//  pend_a      out  1        scoreboard bit of rd_addr_a (combinational)
//  rd_addr_b   in   ADDR_W   read port B address
//  rd_data_b   out  DATA_W   read port B data (combinational)
//  pend_b      out  1        scoreboard bit of rd_addr_b (combinational)
//  we          in   1        write enable
//  wr_addr     in   ADDR_W   write address
//  wr_data     in   DATA_W   write data
//  sb_set      in   1        mark sb_addr pending (producer issued)
//  sb_addr     in   ADDR_W   scoreboard set address
//  clr_req     in   1        start bulk clear (sampled in IDLE only)
//  clr_busy    out  1        high while the clear sequencer is in CLEAR
//  clr_done    out  1        one-cycle pulse when the clear completes
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//  - All registers = 0 and all pending bits = 0.
//  - FSM = IDLE, index = 0, clr_busy = 0, clr_done = 0.
//  - Read outputs therefore show 0 and pend_* = 0 from the next cycle.
//  Write:
//  - If we=1, wr_data is stored at wr_addr on the posedge; the new value is readable the next cycle.
//  - BYPASS=1: when rd_addr_x==wr_addr and we=1 (write accepted), rd_data_x = wr_data in the same cycle.
//  - BYPASS=0: rd_data_x returns the old contents until the next cycle.
//  - ZERO_R0=1: writes to address 0 are dropped; reads of address 0 return 0, with no bypass.
//  Scoreboard:
//  - sb_set=1 sets pend[sb_addr] at the posedge.
//  - An accepted write to wr_addr clears pend[wr_addr] at the posedge.
//  - Set and write on the same address in the same cycle: set wins, so the bit stays 1 (a new producer is in flight).
//  - ZERO_R0=1: sb_set to address 0 is ignored.
//  - pend_x reflects the registered bits only; there is no bypass of same-cycle set/clear.
//  Clear FSM, states IDLE / CLEAR / DONE:
//  - IDLE: clr_req=1 -> CLEAR at the next edge; all pending bits are cleared at that edge and index = 0.
//  - CLEAR: clr_busy=1. Each cycle writes 0 to reg[index] and then increments index.
//    The cycle with index==DEPTH-1 -> DONE. Duration is exactly DEPTH cycles.
//  - DONE: clr_done=1 for one cycle, clr_busy=0 -> IDLE.
//  - In CLEAR and DONE: we and sb_set are ignored (dropped, not queued), clr_req is ignored, and no bypass is applied.
//  - While in CLEAR, reads return current array contents, so registers not yet cleared show their old values.
//  - The index counter is ADDR_W bits and does not wrap past DEPTH-1.
//  - rst during CLEAR aborts immediately to IDLE with the full reset state.
//  Arithmetic/width:
//  - No arithmetic on data.
//  - Addresses are always in range because DEPTH = 2**ADDR_W.
// TESTING
//  1. rst 2 cycles; read all addresses -> every rd_data=0, pend=0, clr_busy=0, clr_done=0.
//  2. we=1, wr_addr=3, wr_data=0xA5, rd_addr_a=3, BYPASS=1 -> rd_data_a=0xA5 in the same cycle.
//     Repeat with BYPASS=0 -> rd_data_a=0x00 that cycle and 0xA5 the next.
//  3. sb_set addr 5 -> pend_b=1 next cycle (rd_addr_b=5).
//     we addr5=0x3C -> pend_b=0 next cycle.
//     sb_set and we on addr 5 in the same cycle -> pend_b stays 1 and rd_data_b=0x3C.
//  4. Fill all regs with 0xFF, pulse clr_req (DEPTH=8) -> clr_busy high exactly 8 cycles, then clr_done pulses once.
//     All regs read 0. A we=1 (addr 2, 0x11) issued mid-clear is dropped, so addr 2 reads 0.
//  5. Start a clear, assert rst on the 4th CLEAR cycle -> next cycle: IDLE, all regs 0, clr_busy=0, clr_done never pulses.
//  6. ZERO_R0=1: we addr0=0x77 and sb_set addr0 -> rd_data=0 and pend=0 on address 0.

Source files
------------

// File: rtl/cpu_regfile_mp.sv
// ============================================================================
// Module  : cpu_regfile_mp
// Brief   : 2R/1W register file with write bypass, pending scoreboard and
//           a one-register-per-cycle bulk-clear sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_regfile_mp #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              pend_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              pend_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [DEPTH-1:0]    pend_q, pend_d;

  logic wr_ok;
  logic sb_ok;

  // Writes and producer issues are only honoured while the sequencer is idle.
  assign wr_ok = (state_q == S_IDLE) && we && !(ZERO_R0 && (wr_addr == '0));
  assign sb_ok = (state_q == S_IDLE) && sb_set && !(ZERO_R0 && (sb_addr == '0));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mem_d    = mem_q;
    pend_d   = pend_q;
    clr_busy = 1'b0;
    clr_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_ok) begin
          mem_d[wr_addr]  = wr_data;
          pend_d[wr_addr] = 1'b0;
        end
        // A set after the write-clear lets a new producer win on the same address.
        if (sb_ok) begin
          pend_d[sb_addr] = 1'b1;
        end
        if (clr_req) begin
          state_d = S_CLEAR;
          idx_d   = '0;
          pend_d  = '0;
        end
      end
      S_CLEAR: begin
        clr_busy     = 1'b1;
        mem_d[idx_q] = '0;
        if (idx_q == ADDR_W'(DEPTH - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        clr_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      mem_q   <= '{default: '0};
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mem_q   <= mem_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    rd_data_a = mem_q[rd_addr_a];
    if (BYPASS && wr_ok && (rd_addr_a == wr_addr)) begin
      rd_data_a = wr_data;
    end
    if (ZERO_R0 && (rd_addr_a == '0)) begin
      rd_data_a = '0;
    end
    rd_data_b = mem_q[rd_addr_b];
    if (BYPASS && wr_ok && (rd_addr_b == wr_addr)) begin
      rd_data_b = wr_data;
    end
    if (ZERO_R0 && (rd_addr_b == '0)) begin
      rd_data_b = '0;
    end
  end

  assign pend_a = pend_q[rd_addr_a];
  assign pend_b = pend_q[rd_addr_b];

endmodule

`default_nettype wire

// File: tb/tb_cpu_regfile_mp.sv
// ============================================================================
// Module  : tb_cpu_regfile_mp
// Brief   : Directed self-checking bench; three DUT variants share stimulus.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_regfile_mp;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rd_addr_a, rd_addr_b, wr_addr, sb_addr;
  logic [7:0] wr_data;
  logic       we, sb_set, clr_req;

  logic [7:0] rda_1, rdb_1, rda_0, rdb_0, rda_z, rdb_z;
  logic       pa_1, pb_1, pa_0, pb_0, pa_z, pb_z;
  logic       busy_1, done_1, busy_0, done_0, busy_z, done_z;

  int passed = 0;
  int total  = 0;
  int busy_cnt, done_cnt, done_cyc;

  always #5 clk = ~clk;

  cpu_regfile_mp #(.DATA_W(8), .ADDR_W(3), .BYPASS(1'b1), .ZERO_R0(1'b0)) u_dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_data_a(rda_1), .pend_a(pa_1),
    .rd_addr_b(rd_addr_b), .rd_data_b(rdb_1), .pend_b(pb_1),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .clr_req(clr_req), .clr_busy(busy_1), .clr_done(done_1)
  );

  cpu_regfile_mp #(.DATA_W(8), .ADDR_W(3), .BYPASS(1'b0), .ZERO_R0(1'b0)) u_nb (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_data_a(rda_0), .pend_a(pa_0),
    .rd_addr_b(rd_addr_b), .rd_data_b(rdb_0), .pend_b(pb_0),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .clr_req(clr_req), .clr_busy(busy_0), .clr_done(done_0)
  );

  cpu_regfile_mp #(.DATA_W(8), .ADDR_W(3), .BYPASS(1'b1), .ZERO_R0(1'b1)) u_z0 (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_data_a(rda_z), .pend_a(pa_z),
    .rd_addr_b(rd_addr_b), .rd_data_b(rdb_z), .pend_b(pb_z),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .clr_req(clr_req), .clr_busy(busy_z), .clr_done(done_z)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Returns 1 ns after the rising edge so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; sb_set = 1'b0; clr_req = 1'b0;
    rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0; sb_addr = '0; wr_data = '0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
      #1;
      chk($sformatf("rst_rda%0d", i), rda_1, 8'h00);
      chk($sformatf("rst_rdb%0d", i), rdb_1, 8'h00);
      chk($sformatf("rst_pa%0d", i), {7'd0, pa_1}, 8'h00);
      chk($sformatf("rst_pb%0d", i), {7'd0, pb_1}, 8'h00);
    end
    chk("rst_busy", {7'd0, busy_1}, 8'h00);
    chk("rst_done", {7'd0, done_1}, 8'h00);

    // Write with and without bypass
    we = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5; rd_addr_a = 3'd3;
    #1;
    chk("byp1_same", rda_1, 8'hA5);
    chk("byp0_same", rda_0, 8'h00);
    tick();
    we = 1'b0;
    #1;
    chk("byp1_next", rda_1, 8'hA5);
    chk("byp0_next", rda_0, 8'hA5);

    // Scoreboard set / clear / set-wins
    rd_addr_b = 3'd5; sb_set = 1'b1; sb_addr = 3'd5;
    tick();
    sb_set = 1'b0;
    #1;
    chk("sb_set", {7'd0, pb_1}, 8'h01);
    we = 1'b1; wr_addr = 3'd5; wr_data = 8'h3C;
    #1;
    chk("sb_no_bypass", {7'd0, pb_1}, 8'h01);
    tick();
    we = 1'b0;
    #1;
    chk("sb_wr_clear", {7'd0, pb_1}, 8'h00);
    chk("sb_wr_data", rdb_1, 8'h3C);
    sb_set = 1'b1; sb_addr = 3'd5; we = 1'b1; wr_addr = 3'd5; wr_data = 8'h3C;
    tick();
    sb_set = 1'b0; we = 1'b0;
    #1;
    chk("sb_set_wins", {7'd0, pb_1}, 8'h01);
    chk("sb_set_wins_data", rdb_1, 8'h3C);

    // Bulk clear
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; wr_addr = 3'(i); wr_data = 8'hFF;
      tick();
    end
    we = 1'b0;
    sb_set = 1'b1; sb_addr = 3'd6;
    tick();
    sb_set = 1'b0;
    rd_addr_b = 3'd6;
    #1;
    chk("pre_clr_pend6", {7'd0, pb_1}, 8'h01);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    rd_addr_a = 3'd7;
    busy_cnt = 0; done_cnt = 0; done_cyc = -1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      #1;
      if (busy_1) busy_cnt++;
      if (done_1) begin done_cnt++; done_cyc = cyc; end
      if (cyc == 0) begin
        chk("clr_old_val7", rda_1, 8'hFF);
        chk("clr_pend_cleared", {7'd0, pb_1}, 8'h00);
      end
      if (cyc == 4) begin
        we = 1'b1; wr_addr = 3'd2; wr_data = 8'h11;
        sb_set = 1'b1; sb_addr = 3'd3; rd_addr_a = 3'd2;
        #1;
        chk("clr_no_bypass", rda_1, 8'h00);
      end else begin
        we = 1'b0; sb_set = 1'b0;
      end
      tick();
    end
    chk("clr_busy_cycles", 8'(busy_cnt), 8'd8);
    chk("clr_done_pulses", 8'(done_cnt), 8'd1);
    chk("clr_done_cycle", 8'(done_cyc), 8'd8);
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i);
      #1;
      chk($sformatf("clr_rd%0d", i), rda_1, 8'h00);
      chk($sformatf("clr_pend%0d", i), {7'd0, pa_1}, 8'h00);
    end

    // Reset aborts a clear in progress
    we = 1'b1; wr_addr = 3'd6; wr_data = 8'h42;
    tick();
    we = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick(); tick(); tick();
    #1;
    chk("abort_busy_pre", {7'd0, busy_1}, 8'h01);
    rd_addr_a = 3'd6;
    #1;
    chk("abort_old6", rda_1, 8'h42);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", {7'd0, busy_1}, 8'h00);
    chk("abort_rd6", rda_1, 8'h00);
    done_cnt = 0; busy_cnt = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (done_1) done_cnt++;
      if (busy_1) busy_cnt++;
      tick();
    end
    chk("abort_no_done", 8'(done_cnt), 8'd0);
    chk("abort_no_busy", 8'(busy_cnt), 8'd0);

    // Hardwired-zero register 0
    we = 1'b1; wr_addr = 3'd0; wr_data = 8'h77;
    sb_set = 1'b1; sb_addr = 3'd0; rd_addr_a = 3'd0;
    #1;
    chk("z0_no_bypass", rda_z, 8'h00);
    chk("r0_bypass", rda_1, 8'h77);
    tick();
    we = 1'b0; sb_set = 1'b0;
    #1;
    chk("z0_rd", rda_z, 8'h00);
    chk("z0_pend", {7'd0, pa_z}, 8'h00);
    chk("r0_rd", rda_1, 8'h77);
    chk("r0_pend", {7'd0, pa_1}, 8'h01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
